cache_arbiter: RTL and testbench

- Shares the single physical-memory port between the I-cache and D-cache miss/writeback paths of the pipelined LC-3b core.
- Sits between both caches' pmem interfaces and main memory.
- Serializes line transfers, with D-cache priority because a D-cache miss stalls the whole pipeline.
- Ages waiting I-cache requests so fetch is never starved.

---
 rtl/cache_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache and the
// D-cache. The D-cache has priority. A waiting I-cache request is forced through
// after STARVE_LIMIT consecutive D grants (STARVE_LIMIT = 0 gives strict D priority).
//
// Optional feature macro: CACHE_ARBITER_PERF_EN (adds grant/conflict counters).
//
// Ports:
//   clk, reset                          rising-edge clock, async active-high reset
//   i_pmem_read/address                 I-cache line read request (held until resp)
//   i_pmem_rdata/resp                   line data and one-cycle completion to I-cache
//   d_pmem_read/write/address/wdata     D-cache line read / writeback request
//   d_pmem_rdata/resp                   line data and one-cycle completion to D-cache
//   pmem_read/write                     memory strobes, decoded from state
//   pmem_address/wdata                  registered copy of the granted request
//   pmem_rdata/resp                     memory read data and completion pulse
//   i_grant_count, d_grant_count,
//   conflict_count                      16-bit wrapping counters (0 without the macro)
module cache_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned LINE_WIDTH   = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [15:0]           i_grant_count,
    output logic [15:0]           d_grant_count,
    output logic [15:0]           conflict_count
);

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, TURN} state_t;

    state_t                state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req, d_req, i_forced, grant_i, grant_d;

    // Read data is a plain passthrough; only meaningful while the resp pulse is high.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Grant decision, only evaluated in IDLE.
    always_comb begin
        i_req    = i_pmem_read;
        d_req    = d_pmem_read | d_pmem_write;
        i_forced = (STARVE_LIMIT != 0) && (32'(starve_cnt_q) >= STARVE_LIMIT);
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                grant_i = i_forced;
                grant_d = !i_forced;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Next-state, captured request and strobe/response decode.
    always_comb begin
        state_d      = state_q;
        op_write_d   = op_write_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = SERVE_I;
                    addr_d       = i_pmem_address;
                    op_write_d   = 1'b0;
                    starve_cnt_d = '0;
                end else if (grant_d) begin
                    state_d    = SERVE_D;
                    addr_d     = d_pmem_address;
                    wdata_d    = d_pmem_wdata;
                    // Write wins when read and write are raised together.
                    op_write_d = d_pmem_write;
                    if (!i_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                    end
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_d     = TURN;
                end
            end
            SERVE_D: begin
                pmem_read  = !op_write_q;
                pmem_write = op_write_q;
                if (pmem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_d     = TURN;
                end
            end
            // One dead cycle so the served requester can drop its request.
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_write_q   <= 1'b0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_write_q   <= op_write_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

`ifdef CACHE_ARBITER_PERF_EN
    logic [15:0] i_cnt_q, d_cnt_q, conf_cnt_q;

    // Wrapping performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (grant_i) i_cnt_q <= i_cnt_q + 16'd1;
            if (grant_d) d_cnt_q <= d_cnt_q + 16'd1;
            if ((state_q == IDLE) && i_req && d_req) conf_cnt_q <= conf_cnt_q + 16'd1;
        end
    end

    assign i_grant_count  = i_cnt_q;
    assign d_grant_count  = d_cnt_q;
    assign conflict_count = conf_cnt_q;
`else
    assign i_grant_count  = '0;
    assign d_grant_count  = '0;
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: random I/D requesters and a random-latency
// memory; a rule-level arbitration model predicts each transfer, a monitor checks it.
module tb_cache_arbiter;

    localparam int unsigned AW     = 16;
    localparam int unsigned LW     = 128;
    localparam int unsigned LIM    = 4;
    localparam int          N_RAND = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read, d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata, d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;
    logic          pmem_resp;
    logic [15:0]   i_grant_count, d_grant_count, conflict_count;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count),
        .conflict_count(conflict_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    bit   m_busy = 0;
    int   m_wait = 0;
    int   m_starve = 0;
    int   m_ig = 0, m_dg = 0, m_conf = 0;
    int   i_gnt_num = 0, d_gnt_num = 0;
    exp_t m_e;

    // At each edge where the port is free: D first, unless I has watched LIM
    // consecutive D grants. A transfer frees the port two edges after its resp.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_busy = 0; m_wait = 0; m_starve = 0;
            m_ig = 0; m_dg = 0; m_conf = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (pmem_resp) begin
                m_busy = 0;
                m_wait = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (i_pmem_read || d_pmem_read || d_pmem_write) begin
            bit both, pick_i;
            both   = i_pmem_read && (d_pmem_read || d_pmem_write);
            pick_i = both ? (LIM != 0 && m_starve >= int'(LIM)) : i_pmem_read;
            if (both) m_conf++;
            m_e.cyc = cyc;
            if (pick_i) begin
                m_e.is_d = 0; m_e.wr = 0; m_e.addr = i_pmem_address; m_e.wdata = '0;
                m_starve = 0;
                m_ig++;
                i_gnt_num++;
            end else begin
                m_e.is_d = 1; m_e.wr = d_pmem_write; m_e.addr = d_pmem_address;
                m_e.wdata = d_pmem_wdata;
                m_starve = i_pmem_read ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
                m_dg++;
                d_gnt_num++;
            end
            exp_q.push_back(m_e);
            m_busy = 1;
        end
    end

    // ---------------- memory ----------------
    int phase = 0;
    int stray_num = 0;
    int stray_seen = 0;
    int mem_cnt = 0;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (reset) begin
                mem_cnt = 0;
            end else if (stray_num != stray_seen) begin
                stray_seen = stray_num;
                pmem_resp  = 1'b1;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    pmem_resp = 1'b1;
                    if (phase == 3) pmem_rdata = {8{16'hA5A5}};
                end
            end else if (pmem_read || pmem_write) begin
                mem_cnt = int'($urandom_range(1, 5));
            end
        end
    end

    // ---------------- monitor ----------------
    bit            mon_prev = 0, mon_d = 0, mon_wr = 0, strb, exp_i, exp_d;
    logic [AW-1:0] mon_a = '0;
    logic [LW-1:0] mon_w = '0;
    exp_t          mon_e;

    initial forever begin
        @(negedge clk);
        #2;
        strb = pmem_read | pmem_write;
        if (strb) check("no_overlap", LW'(pmem_read & pmem_write), '0);
        if (strb && !mon_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_transfer: got addr %0h expected none", pmem_address);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_d  = mon_e.is_d;
                mon_wr = mon_e.wr;
                mon_a  = mon_e.addr;
                mon_w  = mon_e.wdata;
                check("strobe_write", LW'(pmem_write), LW'(mon_e.wr));
                check("strobe_latency", LW'(cyc), LW'(mon_e.cyc));
            end
        end
        if (strb) begin
            check("pmem_address", LW'(pmem_address), LW'(mon_a));
            if (mon_wr) check("pmem_wdata", pmem_wdata, mon_w);
        end
        exp_i = pmem_resp && strb && !mon_d;
        exp_d = pmem_resp && strb && mon_d;
        if (pmem_resp || i_pmem_resp || d_pmem_resp) begin
            check("i_pmem_resp", LW'(i_pmem_resp), LW'(exp_i));
            check("d_pmem_resp", LW'(d_pmem_resp), LW'(exp_d));
        end
        if (i_pmem_resp) check("i_rdata", i_pmem_rdata, pmem_rdata);
        if (d_pmem_resp) check("d_rdata", d_pmem_rdata, pmem_rdata);
        mon_prev = strb;
    end

    // ---------------- I-cache requester ----------------
    bit            i_done = 0, i_done2 = 0;
    logic [LW-1:0] last_i_rdata = '0;

    task automatic i_request(input logic [AW-1:0] a);
        int seen;
        bit got;
        got  = 0;
        seen = i_gnt_num;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (i_pmem_resp) begin
                got = 1;
                last_i_rdata = i_pmem_rdata;
                break;
            end
            if (i_gnt_num != seen) begin
                seen = i_gnt_num;
                i_pmem_address = AW'($urandom);
            end
        end
        i_pmem_read = 1'b0;
        if (!got) fail_now("i_resp_wait");
    endtask

    initial begin
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        wait (phase == 1);
        @(negedge clk);
        #1;
        for (int n = 0; n < N_RAND; n++) begin
            repeat ($urandom_range(0, 6)) begin
                @(negedge clk);
                #1;
            end
            i_request(AW'($urandom));
        end
        i_done = 1;
        wait (phase == 3);
        @(negedge clk);
        #1;
        i_request(16'h1230);
        check("i_directed_rdata", last_i_rdata, {8{16'hA5A5}});
        i_done2 = 1;
    end

    // ---------------- D-cache requester ----------------
    bit d_done = 0, d_done2 = 0;

    task automatic d_request(input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [LW-1:0] w, input bit may_drop, input bit abort_rst);
        int seen;
        bit got;
        got  = 0;
        seen = d_gnt_num;
        d_pmem_read    = rd;
        d_pmem_write   = wr;
        d_pmem_address = a;
        d_pmem_wdata   = w;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (abort_rst && reset) begin
                got = 1;
                break;
            end
            if (d_pmem_resp) begin
                got = 1;
                break;
            end
            if (d_gnt_num != seen) begin
                seen = d_gnt_num;
                d_pmem_address = AW'($urandom);
                d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
                if (may_drop && $urandom_range(0, 3) == 0) begin
                    d_pmem_read  = 1'b0;
                    d_pmem_write = 1'b0;
                end
            end
        end
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        if (!got) fail_now("d_resp_wait");
    endtask

    initial begin
        int op;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        wait (phase == 1);
        @(negedge clk);
        #1;
        // Back-to-back writebacks keep D busy to force the I-aging path.
        for (int n = 0; n < 6; n++)
            d_request(1'b0, 1'b1, AW'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        for (int n = 0; n < N_RAND; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
            op = int'($urandom_range(0, 2));
            d_request(op != 1, op != 0, AW'($urandom),
                      {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        end
        d_done = 1;
        wait (phase == 2);
        @(negedge clk);
        #1;
        d_request(1'b1, 1'b1, 16'h4000, {8{16'hDEAD}}, 1'b0, 1'b1);
        d_done2 = 1;
    end

    // ---------------- sequencing ----------------
    task automatic check_idle_outputs(input string tag);
        check({tag, "_pmem_read"}, LW'(pmem_read), '0);
        check({tag, "_pmem_write"}, LW'(pmem_write), '0);
        check({tag, "_pmem_address"}, LW'(pmem_address), '0);
        check({tag, "_pmem_wdata"}, pmem_wdata, '0);
        check({tag, "_i_resp"}, LW'(i_pmem_resp), '0);
        check({tag, "_d_resp"}, LW'(d_pmem_resp), '0);
    endtask

    initial begin
        int gb;
        bit ok;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_idle_outputs("reset");
        check("reset_i_cnt", LW'(i_grant_count), '0);
        check("reset_d_cnt", LW'(d_grant_count), '0);
        check("reset_conf_cnt", LW'(conflict_count), '0);
        reset = 1'b0;
        phase = 1;

        ok = 0;
        for (int t = 0; t < 20000; t++) begin
            if (i_done && d_done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("random_phase");
        repeat (4) @(negedge clk);
        #3;
`ifdef CACHE_ARBITER_PERF_EN
        check("i_grant_count", LW'(i_grant_count), LW'(16'(m_ig)));
        check("d_grant_count", LW'(d_grant_count), LW'(16'(m_dg)));
        check("conflict_count", LW'(conflict_count), LW'(16'(m_conf)));
`else
        check("i_grant_count_off", LW'(i_grant_count), '0);
        check("d_grant_count_off", LW'(d_grant_count), '0);
        check("conflict_count_off", LW'(conflict_count), '0);
`endif

        // Read+write at 0x4000, then reset while the writeback is in service.
        gb = d_gnt_num;
        phase = 2;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #3;
            if (d_gnt_num != gb) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("d_directed_grant");
        check("dir_pmem_write", LW'(pmem_write), LW'(1'b1));
        check("dir_pmem_read", LW'(pmem_read), '0);
        check("dir_addr_held", LW'(pmem_address), LW'(16'h4000));
        check("dir_wdata_held", pmem_wdata, {8{16'hDEAD}});
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (d_done2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("d_directed_done");
        repeat (2) @(negedge clk);
        #3;
        reset = 1'b0;
        stray_num++;
        repeat (3) @(negedge clk);

        phase = 3;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            if (i_done2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("i_directed_done");
        repeat (4) @(negedge clk);
        check("scoreboard_drained", LW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
